// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
//   N_REQ      : number of requesters
//   SEG_DIGIT  : seven-segment patterns for digits 0..7. The patterns are
//                active-low and ordered {g,f,e,d,c,b,a}.
//   SEG_BLANK  : all segments off
//   arb_state_t: arbiter FSM states
package arb_pkg;

  localparam int unsigned N_REQ = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:7] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78
  };

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin selector for eight requesters.
// The search starts at ptr and picks the first set request bit found,
// wrapping modulo 8.
//   req [7:0] : request vector
//   ptr [2:0] : highest-priority index
//   any       : at least one request is set
//   idx [2:0] : selected requester (0 when any = 0)
module rr_pick8
  import arb_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       any,
  output logic [2:0] idx
);

  logic [15:0] doubled;
  logic [7:0]  rot;
  logic [2:0]  low;

  // Rotate right by ptr, so requester ptr lands on bit 0.
  assign doubled = {req, req} >> ptr;
  assign rot     = doubled[7:0];

  // Find the lowest set bit. The loop scans downward, so the last hit wins.
  always_comb begin
    low = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (rot[i-1]) low = 3'(i - 1);
    end
  end

  assign any = |req;
  assign idx = any ? 3'(low + ptr) : '0;

endmodule

// File: rtl/arb_rr8.sv
// Round-robin arbiter for eight requesters that share one resource.
// A grant is held until the resource asserts done or the owner drops
// its request. The owner index is also driven to the LEDs and to the
// seven-segment display.
// Optional feature: define ARB_TIMEOUT_EN to revoke any grant held for
// TIMEOUT cycles. A revocation pulses the timeout output for one cycle.
//   clk, rst  : clock and synchronous active-high reset
//   req[7:0]  : level-sensitive requests
//   done      : the resource has finished with the current owner
//   gnt[7:0]  : one-hot grant
//   gnt_id    : binary owner index
//   gnt_valid : high while a grant is held
//   led[2:0]  : copy of gnt_id
//   seg[6:0]  : display pattern for gnt_id (blank when idle)
//   timeout   : one-cycle pulse on forced revocation
module arb_rr8
  import arb_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic [2:0]   gnt_id,
  output logic         gnt_valid,
  output logic [2:0]   led,
  output logic [6:0]   seg,
  output logic         timeout
);

  arb_state_t state;
  logic [2:0] ptr;
  logic       pick_any;
  logic [2:0] pick_idx;
  logic       owner_gone;
  logic       expire;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_gone = ~req[gnt_id];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       timeout_q;

  // The counter holds the number of GRANT cycles already completed. The
  // revocation therefore fires on the edge that ends cycle number TIMEOUT.
  assign expire  = (9'(hold_cnt) + 9'd1 >= 9'(TIMEOUT));
  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      led       <= '0;
      seg       <= SEG_BLANK;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= GRANT;
            gnt       <= N'(1) << pick_idx;
            gnt_id    <= pick_idx;
            gnt_valid <= 1'b1;
            led       <= pick_idx;
            seg       <= SEG_DIGIT[pick_idx];
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        GRANT: begin
          if (done || owner_gone || expire) begin
            state     <= IDLE;
            ptr       <= 3'(gnt_id + 3'd1);
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            led       <= '0;
            seg       <= SEG_BLANK;
`ifdef ARB_TIMEOUT_EN
            // Report a timeout only when nothing else caused the release.
            timeout_q <= ~done & ~owner_gone;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_rr8.sv
// Self-checking bench for arb_rr8. A behavioural model predicts the
// outputs each cycle from the arbitration rules: who owns the resource,
// where the priority search starts, and how long the grant has been held.
module tb_arb_rr8;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic [2:0] led;
  logic [6:0] seg;
  logic       timeout;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state
  int m_owner = -1;   // -1 means idle
  int m_ptr   = 0;
  int m_held  = 0;
  int m_tpulse = 0;
  int grant_log[$];

`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic [6:0] seg_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  always #5 clk = ~clk;

  arb_rr8 #(.N(8), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .led       (led),
    .seg       (seg),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic d, input logic rs);
    bit rel;
    bit tmo;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_tpulse = 0;
    end else if (m_owner < 0) begin
      m_tpulse = 0;
      for (int k = 0; k < 8; k++) begin
        int i;
        i = (m_ptr + k) % 8;
        if (r[i]) begin
          m_owner = i; m_held = 0;
          grant_log.push_back(i);
          break;
        end
      end
    end else begin
      tmo = TMO_EN && (m_held + 1 >= TMO);
      rel = d || !r[m_owner] || tmo;
      if (rel) begin
        m_tpulse = (tmo && !d && r[m_owner]) ? 1 : 0;
        m_ptr = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_held++;
        m_tpulse = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] eg;
    logic [2:0] eid;
    eg  = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    eid = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_id", 32'(gnt_id), 32'(eid));
    check("gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check("led", 32'(led), 32'(eid));
    check("seg", 32'(seg), (m_owner < 0) ? 32'h7F : 32'(seg_tab[eid]));
    check("timeout", 32'(timeout), 32'(m_tpulse));
  endtask

  // Drive one cycle of inputs, advance the model, then compare just after the edge.
  task automatic step(input logic [7:0] r, input logic d, input logic rs);
    @(negedge clk);
    req = r; done = d; rst = rs;
    model_step(r, d, rs);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  int tcount;

  initial begin
    req = '0; done = 1'b0; rst = 1'b1;
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0);

    // 0 and 7 alternate, including the wrap from 7 back to 0.
    grant_log.delete();
    step(8'h81, 1'b0, 1'b0);          // grant 0
    check("dir_first0", 32'(gnt_id), 32'd0);
    step(8'h81, 1'b1, 1'b0);          // release
    step(8'h81, 1'b0, 1'b0);          // grant 7
    check("dir_then7", 32'(gnt_id), 32'd7);
    check("dir_seg7", 32'(seg), 32'h78);
    step(8'h81, 1'b1, 1'b0);
    step(8'h81, 1'b0, 1'b0);
    check("dir_wrap0", 32'(gnt_id), 32'd0);
    step(8'h81, 1'b1, 1'b0);

    // All requesting, done on every grant cycle: 1,2,...,7,0,1.
    grant_log.delete();
    for (int i = 0; i < 18; i++) step(8'hFF, (i % 2) == 1, 1'b0);
    for (int i = 0; i < 9; i++)
      check("ff_seq", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF, 32'((i + 1) % 8));

    // The owner abandons its request.
    step(8'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0);          // grant 3
    check("drop_own3", 32'(gnt_id), 32'd3);
    step(8'h28, 1'b0, 1'b0);          // 5 joins, 3 keeps it
    step(8'h20, 1'b0, 1'b0);          // 3 drops -> release
    step(8'h20, 1'b0, 1'b0);          // grant 5
    check("drop_then5", 32'(gnt_id), 32'd5);
    step(8'h20, 1'b1, 1'b0);

    // Sole requester 2, no done: timeout revocations when enabled.
    tcount = 0;
    for (int i = 0; i < 14; i++) begin
      step(8'h04, 1'b0, 1'b0);
      if (timeout) tcount++;
    end
    check("tmo_pulses", 32'(tcount), TMO_EN ? 32'd2 : 32'd0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // Reset in the middle of a grant to 6.
    step(8'h40, 1'b0, 1'b0);
    check("rst_own6", 32'(gnt_id), 32'd6);
    step(8'h40, 1'b0, 1'b1);
    step(8'h41, 1'b0, 1'b0);
    check("rst_then0", 32'(gnt_id), 32'd0);
    step(8'h41, 1'b1, 1'b0);

    // Random traffic, with the occasional reset.
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
      step(r, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
